// File: rtl/spi_master_ctrl_if.sv
// Word-level request/response bus of spi_master_ctrl: per-transfer configuration,
// transmit word with ready/valid, received word with a completion pulse.
interface spi_master_ctrl_if #(
  parameter int unsigned word_width = 8,
  parameter int unsigned SS_width   = 1,
  parameter int unsigned div_width  = 8
) ();
  localparam int unsigned ssv_width = $clog2((SS_width > 2) ? SS_width : 2);

  logic                  CPOL;
  logic                  CPHA;
  logic                  LSBF;
  logic [div_width-1:0]  DIV;
  logic [ssv_width-1:0]  SSV;
  logic [word_width-1:0] D_IN;
  logic                  in_valid;
  logic                  in_ready;
  logic [word_width-1:0] D_OUT;
  logic                  out_valid;
  logic                  busy;

  modport master (
    output CPOL, CPHA, LSBF, DIV, SSV, D_IN, in_valid,
    input  in_ready, D_OUT, out_valid, busy
  );

  modport slave (
    input  CPOL, CPHA, LSBF, DIV, SSV, D_IN, in_valid,
    output in_ready, D_OUT, out_valid, busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Full-duplex SPI master: one word per transaction, programmable SCLK divider, all CPOL/CPHA
// modes, MSB/LSB-first order, decoded slave select. SPI_MASTER_LOOPBACK_EN adds the LB port.
module spi_master_ctrl #(
  parameter int unsigned word_width = 8,
  parameter int unsigned SS_width   = 1,
  parameter int unsigned div_width  = 8
) (
  input  logic                clk,
  input  logic                rst,
  spi_master_ctrl_if.slave    bus,
  output logic                SCLK,
  input  logic                SD_IN,
  output logic                SD_OUT,
  output logic [SS_width-1:0] SS_OUT
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic                LB
`endif
);

  localparam int unsigned ssv_width  = $clog2((SS_width > 2) ? SS_width : 2);
  localparam int unsigned bit_width  = $clog2(word_width);
  localparam int unsigned edge_width = $clog2(2 * word_width + 1);
  localparam logic [edge_width-1:0] last_edge = edge_width'(2 * word_width);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  function automatic logic [SS_width-1:0] tree_decoder(input logic [ssv_width-1:0] idx);
    logic [SS_width-1:0] dec;
    dec = '0;
    for (int unsigned i = 0; i < SS_width; i++) begin
      dec[i] = (idx == ssv_width'(i));
    end
    return dec;
  endfunction

  // Word position of the k-th bit on the wire.
  function automatic logic [bit_width-1:0] bit_pos(input logic lsbf,
                                                   input logic [bit_width-1:0] k);
    return lsbf ? k : bit_width'(word_width - 1) - k;
  endfunction

  logic lb_in;
`ifdef SPI_MASTER_LOOPBACK_EN
  assign lb_in = LB;
`else
  assign lb_in = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [div_width-1:0]  hcnt_q, hcnt_d;
  logic [div_width-1:0]  div_q, div_d;
  logic [edge_width-1:0] edge_q, edge_d;
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  lsbf_q, lsbf_d;
  logic                  lb_q, lb_d;
  logic [word_width-1:0] tx_q, tx_d;
  logic [word_width-1:0] rx_q, rx_d;
  logic [word_width-1:0] dout_q, dout_d;
  logic                  ov_q, ov_d;
  logic                  sclk_q, sclk_d;
  logic                  sdo_q, sdo_d;
  logic [SS_width-1:0]   ss_q, ss_d;

  logic [edge_width-1:0] edge_nxt;
  logic [bit_width-1:0]  k_half;
  logic [bit_width-1:0]  sidx;
  logic                  drive;
  logic                  sample;
  logic                  rx_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsbf_q  <= 1'b0;
      lb_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      ss_q    <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsbf_q  <= lsbf_d;
      lb_q    <= lb_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      ss_q    <= ss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    div_d   = div_q;
    edge_d  = edge_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsbf_d  = lsbf_q;
    lb_d    = lb_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    ov_d    = 1'b0;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    ss_d    = ss_q;

    // Edge e = edge_nxt: CPHA=0 drives bit e/2 on even edges and samples bit (e-1)/2 on odd
    // ones; CPHA=1 drives bit (e-1)/2 on odd edges and samples bit e/2-1 on even ones.
    edge_nxt = edge_q + 1'b1;
    k_half   = edge_nxt[bit_width:1];
    drive    = cpha_q ? edge_nxt[0] : (!edge_nxt[0] && (edge_nxt != last_edge));
    sample   = cpha_q ? !edge_nxt[0] : edge_nxt[0];
    sidx     = cpha_q ? k_half - 1'b1 : k_half;
    rx_src   = lb_q ? tx_q[bit_pos(lsbf_q, sidx)] : SD_IN;

    unique case (state_q)
      StIdle: begin
        sclk_d = bus.CPOL;
        ss_d   = '0;
        if (bus.in_valid) begin
          cpol_d  = bus.CPOL;
          cpha_d  = bus.CPHA;
          lsbf_d  = bus.LSBF;
          div_d   = bus.DIV;
          lb_d    = lb_in;
          tx_d    = bus.D_IN;
          rx_d    = '0;
          hcnt_d  = '0;
          edge_d  = '0;
          state_d = StSetup;
          ss_d    = lb_in ? '0 : tree_decoder(bus.SSV);
          if (lb_in) begin
            sdo_d = 1'b0;
          end else if (!bus.CPHA) begin
            sdo_d = bus.D_IN[bit_pos(bus.LSBF, '0)];
          end
        end
      end
      StSetup, StShift: begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == div_q) begin
          hcnt_d = '0;
          edge_d = edge_nxt;
          if (!lb_q) begin
            sclk_d = ~sclk_q;
          end
          if (drive && !lb_q) begin
            sdo_d = tx_q[bit_pos(lsbf_q, k_half)];
          end
          if (sample) begin
            rx_d[bit_pos(lsbf_q, sidx)] = rx_src;
          end
          state_d = (edge_nxt == last_edge) ? StHold : StShift;
        end
      end
      StHold: begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == div_q) begin
          hcnt_d  = '0;
          state_d = StIdle;
          ov_d    = 1'b1;
          dout_d  = rx_q;
          ss_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.D_OUT     = dout_q;
  assign bus.out_valid = ov_q;
  assign SCLK          = sclk_q;
  assign SD_OUT        = sdo_q;
  assign SS_OUT        = ss_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl (W=8, four slave selects) with a mode-aware SPI slave.
module tb_spi_master_ctrl;

  localparam int MaxCyc = 512;

  logic       clk;
  logic       rst;
  logic       sclk;
  logic       sd_in;
  logic       sd_out;
  logic [3:0] ss_out;
  logic       miso;
  logic       loop_en;

  int tests;
  int fails;

  spi_master_ctrl_if #(.word_width(8), .SS_width(4), .div_width(8)) bus ();

  spi_master_ctrl #(
    .word_width(8),
    .SS_width  (4),
    .div_width (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .SCLK  (sclk),
    .SD_IN (sd_in),
    .SD_OUT(sd_out),
    .SS_OUT(ss_out)
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    .LB    (1'b0)
`endif
  );

  assign sd_in = loop_en ? sd_out : miso;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Slave: on the leading edge it samples when CPHA=0, on the trailing edge when CPHA=1.
  logic       s_cpol;
  logic       s_cpha;
  logic [7:0] s_tx;
  logic [7:0] s_sh;
  logic [7:0] s_rx;
  logic       sclk_prev;
  logic       sel_prev;

  always @(negedge clk) begin
    if ((|ss_out) && !sel_prev) begin
      s_rx = 8'h00;
      s_sh = s_tx;
      if (!s_cpha) begin
        miso = s_sh[7];
        s_sh = {s_sh[6:0], 1'b0};
      end
    end else if ((|ss_out) && (sclk != sclk_prev)) begin
      if ((sclk != s_cpol) != s_cpha) begin
        s_rx = {s_rx[6:0], sd_out};
      end else begin
        miso = s_sh[7];
        s_sh = {s_sh[6:0], 1'b0};
      end
    end
    sclk_prev = sclk;
    sel_prev  = |ss_out;
  end

  logic       sclk_log [MaxCyc];
  logic       sdo_log  [MaxCyc];
  logic       rdy_log  [MaxCyc];
  logic       busy_log [MaxCyc];
  logic       ov_log   [MaxCyc];
  logic [3:0] ss_log   [MaxCyc];
  logic [7:0] dout_log [MaxCyc];
  int         ov_cyc;
  int         rises;
  int         poke_cyc;
  int         rst_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle 0; returns at the negedge of cycle 1.
  task automatic send(input logic [7:0] d, input logic cpol, input logic cpha,
                      input logic lsbf, input logic [7:0] div, input logic [1:0] ssv,
                      input bit keep);
    bus.D_IN     = d;
    bus.CPOL     = cpol;
    bus.CPHA     = cpha;
    bus.LSBF     = lsbf;
    bus.DIV      = div;
    bus.SSV      = ssv;
    bus.in_valid = 1'b1;
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Logs outputs from cycle 1 until out_valid or the cycle limit.
  task automatic watch(input int limit);
    ov_cyc = -1;
    rises  = 0;
    for (int c = 1; c < limit; c++) begin
      sclk_log[c] = sclk;
      sdo_log[c]  = sd_out;
      rdy_log[c]  = bus.in_ready;
      busy_log[c] = bus.busy;
      ov_log[c]   = bus.out_valid;
      ss_log[c]   = ss_out;
      dout_log[c] = bus.D_OUT;
      if (c > 1 && sclk_log[c] && !sclk_log[c-1]) rises++;
      if (c == poke_cyc) begin
        bus.CPOL = ~bus.CPOL;
        bus.SSV  = 2'd1;
      end
      rst = (c == rst_cyc);
      if (bus.out_valid) begin
        ov_cyc = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; loop_en = 1'b0; miso = 1'b0;
    bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.LSBF = 1'b0; bus.DIV = 8'd0; bus.SSV = 2'd0;
    bus.D_IN = 8'h00; bus.in_valid = 1'b0;
    s_cpol = 1'b0; s_cpha = 1'b0; s_tx = 8'h00; s_sh = 8'h00; s_rx = 8'h00;
    sclk_prev = 1'b0; sel_prev = 1'b0;
    poke_cyc = -1; rst_cyc = -1;
    repeat (3) @(negedge clk);

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_d_out", bus.D_OUT, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sd_out", sd_out, 0);
    check("rst_ss_out", ss_out, 0);
    rst = 1'b0;
    @(negedge clk);

    // Mode 0, H=1, MOSI looped to MISO.
    loop_en = 1'b1;
    send(8'hA5, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    watch(100);
    check("t1_ov_cycle", ov_cyc, 18);
    check("t1_d_out", bus.D_OUT, 8'hA5);
    check("t1_rises", rises, 8);
    check("t1_ss_c1", ss_log[1], 4'b0001);
    check("t1_ss_c17", ss_log[17], 4'b0001);
    check("t1_ss_c18", ss_log[18], 4'b0000);
    check("t1_busy_c17", busy_log[17], 1);
    check("t1_ready_c18", rdy_log[18], 1);
    check("t1_sdo_c1", sdo_log[1], 1);
    check("t1_sdo_c3", sdo_log[3], 0);
    check("t1_sdo_c5", sdo_log[5], 1);

    // Mode 3, H=4, slave returns 0x3C.
    loop_en = 1'b0;
    s_cpol = 1'b1; s_cpha = 1'b1; s_tx = 8'h3C;
    bus.CPOL = 1'b1;
    @(negedge clk);
    check("t2_idle_high", sclk, 1);
    send(8'h96, 1'b1, 1'b1, 1'b0, 8'd3, 2'd0, 1'b0);
    watch(200);
    check("t2_ov_cycle", ov_cyc, 69);
    check("t2_d_out", bus.D_OUT, 8'h3C);
    check("t2_slave_rx", s_rx, 8'h96);
    check("t2_rises", rises, 8);
    check("t2_sclk_c4", sclk_log[4], 1);
    check("t2_sclk_c5", sclk_log[5], 0);
    check("t2_sclk_c68", sclk_log[68], 1);

    // LSB first, mode 0.
    bus.CPOL = 1'b0;
    s_cpol = 1'b0; s_cpha = 1'b0; s_tx = 8'h80;
    @(negedge clk);
    send(8'h01, 1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 1'b0);
    watch(100);
    check("t3_ov_cycle", ov_cyc, 18);
    check("t3_d_out", bus.D_OUT, 8'h01);
    check("t3_sdo_c1", sdo_log[1], 1);
    check("t3_sdo_c3", sdo_log[3], 0);
    check("t3_sdo_c15", sdo_log[15], 0);
    check("t3_slave_rx", s_rx, 8'h80);

    // SSV=2, H=2; CPOL and SSV changed at cycle 5 must be ignored until the next accept.
    loop_en  = 1'b1;
    poke_cyc = 5;
    send(8'hC4, 1'b0, 1'b0, 1'b0, 8'd1, 2'd2, 1'b0);
    watch(100);
    poke_cyc = -1;
    check("t4_ov_cycle", ov_cyc, 35);
    check("t4_d_out", bus.D_OUT, 8'hC4);
    check("t4_ss_c2", ss_log[2], 4'b0100);
    check("t4_ss_c10", ss_log[10], 4'b0100);
    check("t4_sclk_c7", sclk_log[7], 1);
    check("t4_sclk_c9", sclk_log[9], 0);
    check("t4_sclk_hold", sclk_log[34], 0);
    check("t4_rises", rises, 8);
    @(negedge clk);
    check("t4_idle_new_cpol", sclk, 1);
    bus.CPOL = 1'b0;
    bus.SSV  = 2'd0;
    @(negedge clk);

    // Back-to-back: in_valid held high, second accept in the out_valid cycle.
    send(8'h11, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    bus.D_IN = 8'h22;
    watch(100);
    check("t5a_ov_cycle", ov_cyc, 18);
    check("t5a_d_out", bus.D_OUT, 8'h11);
    check("t5a_ready", rdy_log[18], 1);
    check("t5a_ss_gap", ss_log[18], 4'b0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    watch(100);
    check("t5b_ss_c1", ss_log[1], 4'b0001);
    check("t5b_busy_c1", busy_log[1], 1);
    check("t5b_ov_cycle", ov_cyc, 18);
    check("t5b_d_out", bus.D_OUT, 8'h22);

    // Reset at edge 5 (cycle 6), then a clean transfer.
    @(negedge clk);
    rst_cyc = 6;
    send(8'h33, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    watch(40);
    rst_cyc = -1;
    check("t6_busy_c6", busy_log[6], 1);
    check("t6_no_ov", ov_cyc, -1);
    check("t6_ready_c7", rdy_log[7], 1);
    check("t6_busy_c7", busy_log[7], 0);
    check("t6_ov_c7", ov_log[7], 0);
    check("t6_sclk_c7", sclk_log[7], 0);
    check("t6_sdo_c7", sdo_log[7], 0);
    check("t6_ss_c7", ss_log[7], 4'b0000);
    check("t6_dout_c7", dout_log[7], 8'h00);
    send(8'h5A, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0);
    watch(100);
    check("t6_ov_cycle", ov_cyc, 18);
    check("t6_d_out", bus.D_OUT, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
